maxpool2x2_stream: RTL and testbench

// - Streaming 2x2/stride-2 max-pool stage between the ReLU stage and the linear stage.
// - Consumes a raster-order, valid-qualified, two-channel feature map (FMAP_W x FMAP_H).
// - Emits one pooled value per channel per 2x2 window, (FMAP_W/2)*(FMAP_H/2) results per frame.
// - Holds the even-row partial maxima in a half-width row buffer, so no frame buffer is needed.

---
 rtl/maxpool2x2_stream.sv | 158 +++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream
// Streaming 2x2 / stride-2 max-pool for a two-channel, raster-order,
// valid-qualified feature map of FMAP_W x FMAP_H unsigned samples.
//
// Even-column beats are parked in a per-channel hold register. Odd-column
// beats form a horizontal pair maximum. On even rows that pair maximum goes
// into a half-width row buffer. On odd rows it is combined with the buffered
// value from the row above and emitted as the pooled result.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   in_valid    in   in_data_0/1 carry one pixel this cycle
//   in_data_0   in   channel 0 pixel (DATA_W)
//   in_data_1   in   channel 1 pixel (DATA_W)
//   out_valid   out  one-cycle pulse, out_data_* / out_index valid
//   out_data_0  out  channel 0 pooled maximum (DATA_W)
//   out_data_1  out  channel 1 pooled maximum (DATA_W)
//   out_index   out  pooled position (row/2)*(FMAP_W/2) + col/2 (IDX_W)
//   frame_done  out  pulses with the last out_valid of a frame
// -----------------------------------------------------------------------------
module maxpool2x2_stream #(
    parameter int DATA_W = 8,
    parameter int FMAP_W = 6,
    parameter int FMAP_H = 6,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data_0,
    output logic [DATA_W-1:0] out_data_1,
    output logic [IDX_W-1:0]  out_index,
    output logic              frame_done
);

    localparam int HALF_W = FMAP_W / 2;
    // Row buffer depth is rounded up to a power of two so that the pair
    // column (col_cnt >> 1) indexes it with an exactly matching width.
    localparam int BUF_AW = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int BUF_D  = 1 << BUF_AW;
    localparam int COL_W  = BUF_AW + 1;
    localparam int ROW_W  = $clog2(FMAP_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);

    // Unsigned maximum of two samples.
    function automatic logic [DATA_W-1:0] max_u(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [COL_W-1:0]  col_cnt_r;
    logic [ROW_W-1:0]  row_cnt_r;
    logic [DATA_W-1:0] hold_0_r;
    logic [DATA_W-1:0] hold_1_r;
    logic [IDX_W-1:0]  idx_cnt_r;
    logic [DATA_W-1:0] rowbuf_0_r [BUF_D];
    logic [DATA_W-1:0] rowbuf_1_r [BUF_D];

    logic [BUF_AW-1:0] pair_col_s;
    logic [DATA_W-1:0] pair_0_s;
    logic [DATA_W-1:0] pair_1_s;
    logic [DATA_W-1:0] pool_0_s;
    logic [DATA_W-1:0] pool_1_s;
    logic              col_last_s;
    logic              row_last_s;
    logic              odd_col_s;
    logic              odd_row_s;
    logic              emit_s;

    // Pair/pool maxima and beat classification for the current input.
    always_comb begin
        pair_col_s = col_cnt_r[COL_W-1:1];
        pair_0_s   = max_u(hold_0_r, in_data_0);
        pair_1_s   = max_u(hold_1_r, in_data_1);
        pool_0_s   = max_u(rowbuf_0_r[pair_col_s], pair_0_s);
        pool_1_s   = max_u(rowbuf_1_r[pair_col_s], pair_1_s);
        col_last_s = (col_cnt_r == COL_LAST);
        row_last_s = (row_cnt_r == ROW_LAST);
        odd_col_s  = col_cnt_r[0];
        odd_row_s  = row_cnt_r[0];
        emit_s     = in_valid & odd_col_s & odd_row_s;
    end

    // Raster position counters; next frame starts right after the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt_r <= {COL_W{1'b0}};
            row_cnt_r <= {ROW_W{1'b0}};
        end else if (in_valid) begin
            if (col_last_s) begin
                col_cnt_r <= {COL_W{1'b0}};
                if (row_last_s) begin
                    row_cnt_r <= {ROW_W{1'b0}};
                end else begin
                    row_cnt_r <= row_cnt_r + ROW_W'(1);
                end
            end else begin
                col_cnt_r <= col_cnt_r + COL_W'(1);
            end
        end
    end

    // Horizontal hold of the even-column sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_0_r <= {DATA_W{1'b0}};
            hold_1_r <= {DATA_W{1'b0}};
        end else if (in_valid && !odd_col_s) begin
            hold_0_r <= in_data_0;
            hold_1_r <= in_data_1;
        end
    end

    // Even-row pair maxima; always written before the odd row reads them,
    // so the buffer needs no reset.
    always_ff @(posedge clk) begin
        if (in_valid && odd_col_s && !odd_row_s) begin
            rowbuf_0_r[pair_col_s] <= pair_0_s;
            rowbuf_1_r[pair_col_s] <= pair_1_s;
        end
    end

    // Registered results. Results arrive strictly in index order, so a
    // running count replaces the (row/2)*(FMAP_W/2)+col/2 product.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_data_0 <= {DATA_W{1'b0}};
            out_data_1 <= {DATA_W{1'b0}};
            out_index  <= {IDX_W{1'b0}};
            idx_cnt_r  <= {IDX_W{1'b0}};
        end else begin
            out_valid  <= emit_s;
            frame_done <= emit_s & col_last_s & row_last_s;
            if (emit_s) begin
                out_data_0 <= pool_0_s;
                out_data_1 <= pool_1_s;
                out_index  <= idx_cnt_r;
                if (col_last_s && row_last_s) begin
                    idx_cnt_r <= {IDX_W{1'b0}};
                end else begin
                    idx_cnt_r <= idx_cnt_r + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool2x2_stream
// Directed, self-checking bench for maxpool2x2_stream (6x6, 8-bit, 2 channels).
// Expected pooled values come from a direct 2x2 maximum over the bench's own
// pixel definition; pulses are captured by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_maxpool2x2_stream;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data_0 = 8'd0;
    logic [7:0] in_data_1 = 8'd0;
    logic       out_valid;
    logic [7:0] out_data_0;
    logic [7:0] out_data_1;
    logic [3:0] out_index;
    logic       frame_done;

    maxpool2x2_stream #(
        .DATA_W(8), .FMAP_W(6), .FMAP_H(6), .IDX_W(4)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_data_0(in_data_0), .in_data_1(in_data_1),
        .out_valid(out_valid), .out_data_0(out_data_0), .out_data_1(out_data_1),
        .out_index(out_index), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stray_fd = 0;
    int q_d0[$];
    int q_d1[$];
    int q_idx[$];
    int q_fd[$];
    int q_cyc[$];
    int q_beat[$];

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_d0.push_back(int'(out_data_0));
            q_d1.push_back(int'(out_data_1));
            q_idx.push_back(int'(out_index));
            q_fd.push_back(int'(frame_done));
            q_cyc.push_back(cyc);
        end else if (frame_done !== 1'b0) begin
            stray_fd = stray_fd + 1;
        end
    end

    // Stimulus pixel: mode 0 ramp, mode 1 all-FF, mode 2 single window.
    function automatic logic [7:0] pix(input int mode, input int ch, input int r, input int c);
        int v;
        v = r * 6 + c;
        case (mode)
            0: return (ch == 0) ? 8'(v) : 8'(35 - v);
            1: return 8'hFF;
            default: begin
                if (r == 0 && c == 0) return (ch == 0) ? 8'd0 : 8'd255;
                if (r == 0 && c == 1) return (ch == 0) ? 8'd200 : 8'd1;
                if (r == 1 && c == 0) return (ch == 0) ? 8'd0 : 8'd2;
                if (r == 1 && c == 1) return (ch == 0) ? 8'd0 : 8'd3;
                return 8'd0;
            end
        endcase
    endfunction

    // Reference pooled value for window k.
    function automatic int exp_val(input int mode, input int ch, input int k);
        int m;
        int p;
        m = 0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                p = int'(pix(mode, ch, 2 * (k / 3) + dr, 2 * (k % 3) + dc));
                if (p > m) m = p;
            end
        end
        return m;
    endfunction

    task automatic clear_mon();
        q_d0.delete(); q_d1.delete(); q_idx.delete();
        q_fd.delete(); q_cyc.delete(); q_beat.delete();
        stray_fd = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_beat(input int mode, input int r, input int c);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data_0 = pix(mode, 0, r, c);
        in_data_1 = pix(mode, 1, r, c);
        if ((r % 2 == 1) && (c % 2 == 1)) q_beat.push_back(cyc);
    endtask

    task automatic send_frame(input int mode, input bit gap);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                send_beat(mode, r, c);
                if (gap) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, frame_done, out_data_0, out_data_1, out_index} !== 22'd0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got v=%b fd=%b d0=%0d d1=%0d idx=%0d expected all 0",
                         i, out_valid, frame_done, out_data_0, out_data_1, out_index);
            end
        end
    endtask

    task automatic test_continuous();
        clear_mon();
        send_frame(0, 1'b0);
        idle(3);
        n_checks++;
        if (q_d0.size() != 9) begin
            n_fail++;
            $display("FAIL cont_count: got %0d expected 9", q_d0.size());
        end
        for (int k = 0; k < 9 && k < q_d0.size(); k++) begin
            n_checks++;
            if (q_d0[k] != exp_val(0, 0, k) || q_d1[k] != exp_val(0, 1, k) ||
                q_idx[k] != k || q_fd[k] != ((k == 8) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL cont[%0d]: got d0=%0d d1=%0d idx=%0d fd=%0d expected d0=%0d d1=%0d idx=%0d fd=%0d",
                         k, q_d0[k], q_d1[k], q_idx[k], q_fd[k],
                         exp_val(0, 0, k), exp_val(0, 1, k), k, (k == 8) ? 1 : 0);
            end
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_data_0 !== 8'd35 || out_data_1 !== 8'd7 || out_index !== 4'd8) begin
            n_fail++;
            $display("FAIL cont_hold: got v=%b d0=%0d d1=%0d idx=%0d expected v=0 d0=35 d1=7 idx=8",
                     out_valid, out_data_0, out_data_1, out_index);
        end
    endtask

    task automatic test_gapped();
        clear_mon();
        send_frame(0, 1'b1);
        idle(3);
        n_checks++;
        if (q_d0.size() != 9 || q_beat.size() != 9) begin
            n_fail++;
            $display("FAIL gap_count: got %0d expected 9", q_d0.size());
        end
        for (int k = 0; k < 9 && k < q_d0.size(); k++) begin
            n_checks++;
            if (q_d0[k] != exp_val(0, 0, k) || q_d1[k] != exp_val(0, 1, k) || q_idx[k] != k) begin
                n_fail++;
                $display("FAIL gap[%0d]: got d0=%0d d1=%0d idx=%0d expected d0=%0d d1=%0d idx=%0d",
                         k, q_d0[k], q_d1[k], q_idx[k], exp_val(0, 0, k), exp_val(0, 1, k), k);
            end
            n_checks++;
            if (q_cyc[k] != q_beat[k] + 1) begin
                n_fail++;
                $display("FAIL gap_latency[%0d]: got cycle %0d expected %0d", k, q_cyc[k], q_beat[k] + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(0, 1'b0);
        send_frame(1, 1'b0);
        idle(3);
        n_checks++;
        if (q_d0.size() != 18) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 18", q_d0.size());
        end
        for (int k = 0; k < 18 && k < q_d0.size(); k++) begin
            n_checks++;
            if (q_d0[k] != ((k >= 9) ? 255 : exp_val(0, 0, k)) ||
                q_d1[k] != ((k >= 9) ? 255 : exp_val(0, 1, k)) ||
                q_idx[k] != k % 9 || q_fd[k] != ((k % 9 == 8) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got d0=%0d d1=%0d idx=%0d fd=%0d expected idx=%0d fd=%0d",
                         k, q_d0[k], q_d1[k], q_idx[k], q_fd[k], k % 9, (k % 9 == 8) ? 1 : 0);
            end
        end
        n_checks++;
        if (stray_fd != 0) begin
            n_fail++;
            $display("FAIL b2b_stray_fd: got %0d expected 0", stray_fd);
        end
    endtask

    task automatic test_window();
        clear_mon();
        send_frame(2, 1'b0);
        idle(3);
        n_checks++;
        if (q_d0.size() != 9) begin
            n_fail++;
            $display("FAIL win_count: got %0d expected 9", q_d0.size());
        end else begin
            n_checks++;
            if (q_d0[0] != 200 || q_d1[0] != 255 || q_idx[0] != 0) begin
                n_fail++;
                $display("FAIL win: got d0=%0d d1=%0d idx=%0d expected d0=200 d1=255 idx=0",
                         q_d0[0], q_d1[0], q_idx[0]);
            end
            n_checks++;
            if (q_d0[1] != 0 || q_d1[1] != 0) begin
                n_fail++;
                $display("FAIL win_next: got d0=%0d d1=%0d expected 0 0", q_d0[1], q_d1[1]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        for (int b = 0; b < 20; b++) send_beat(0, b / 6, b % 6);
        idle(2);
        n_checks++;
        if (q_d0.size() != 4) begin
            n_fail++;
            $display("FAIL mid_partial: got %0d pulses expected 4", q_d0.size());
        end
        clear_mon();
        // Reset coincides with a valid beat; that beat must be discarded.
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        in_data_0 = 8'd99;
        in_data_1 = 8'd99;
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        idle(2);
        n_checks++;
        if (q_d0.size() != 0) begin
            n_fail++;
            $display("FAIL mid_after_reset: got %0d pulses expected 0", q_d0.size());
        end
        send_frame(0, 1'b0);
        idle(3);
        n_checks++;
        if (q_d0.size() != 9) begin
            n_fail++;
            $display("FAIL mid_count: got %0d expected 9", q_d0.size());
        end
        for (int k = 0; k < 9 && k < q_d0.size(); k++) begin
            n_checks++;
            if (q_idx[k] != k || q_d0[k] != exp_val(0, 0, k) || q_d1[k] != exp_val(0, 1, k)) begin
                n_fail++;
                $display("FAIL mid[%0d]: got idx=%0d d0=%0d d1=%0d expected idx=%0d d0=%0d d1=%0d",
                         k, q_idx[k], q_d0[k], q_d1[k], k, exp_val(0, 0, k), exp_val(0, 1, k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gapped();
        test_back_to_back();
        test_window();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
